// File: rtl/inicializador_turnos_param.sv
// rtl/inicializador_turnos_param.sv - first-player selection by modulo reduction, then turn rotation
// Optional macro LFSR_INTERNO_EN: internal 16-bit Galois LFSR replaces valor_aleatorio.
module inicializador_turnos_param #(
    parameter int NUM_JUGADORES = 2,
    parameter int RAND_W        = 4,
    localparam int JW           = (NUM_JUGADORES < 2) ? 1 : $clog2(NUM_JUGADORES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_inicial,
    input  logic [RAND_W-1:0] valor_aleatorio,
    input  logic              fin_turno,
    output logic [JW-1:0]     jugador_inicial,
    output logic [JW-1:0]     jugador_actual,
    output logic              listo,
    output logic              ocupado
);

    generate
        if (NUM_JUGADORES < 2 || NUM_JUGADORES > 16) begin : g_err_n
            $error("NUM_JUGADORES must be in 2..16");
        end
        if (RAND_W < JW) begin : g_err_w
            $error("RAND_W must be >= JW");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, REDUCIR, JUGANDO} estado_t;

    estado_t           estado;
    logic [RAND_W-1:0] r;
    logic [RAND_W-1:0] fuente;

`ifdef LFSR_INTERNO_EN
    generate
        if (RAND_W > 16) begin : g_err_lfsr
            $error("RAND_W must be <= 16 with LFSR_INTERNO_EN");
        end
    endgenerate

    logic [15:0] lfsr;

    // Galois form: shift right, fold the taps in when the bit leaving is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ 16'hB400;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    assign fuente = lfsr[RAND_W-1:0];
`else
    assign fuente = valor_aleatorio;
`endif

    assign listo   = (estado == JUGANDO);
    assign ocupado = (estado == REDUCIR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado          <= IDLE;
            r               <= '0;
            jugador_inicial <= '0;
            jugador_actual  <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (start_inicial) begin
                        r      <= fuente;
                        estado <= REDUCIR;
                    end
                end
                REDUCIR: begin
                    // Compare at 32 bits so NUM_JUGADORES may exceed the range of r.
                    if (32'(r) >= NUM_JUGADORES) begin
                        r <= r - RAND_W'(NUM_JUGADORES);
                    end else begin
                        jugador_inicial <= r[JW-1:0];
                        jugador_actual  <= r[JW-1:0];
                        estado          <= JUGANDO;
                    end
                end
                JUGANDO: begin
                    if (start_inicial) begin
                        r      <= fuente;
                        estado <= REDUCIR;
                    end else if (fin_turno) begin
                        if (jugador_actual == JW'(NUM_JUGADORES - 1)) begin
                            jugador_actual <= '0;
                        end else begin
                            jugador_actual <= jugador_actual + 1'b1;
                        end
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inicializador_turnos_param.sv
// tb/tb_inicializador_turnos_param.sv - table-driven bench for inicializador_turnos_param
module tb_inicializador_turnos_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       s2, f2, l2, o2;
    logic [3:0] v2;
    logic [0:0] ji2, ja2;

    logic       s3, f3, l3, o3;
    logic [3:0] v3;
    logic [1:0] ji3, ja3;

    logic       s4, f4, l4, o4;
    logic [3:0] v4;
    logic [1:0] ji4, ja4;

    inicializador_turnos_param #(.NUM_JUGADORES(2), .RAND_W(4)) dut2 (
        .clk(clk), .reset(reset), .start_inicial(s2), .valor_aleatorio(v2), .fin_turno(f2),
        .jugador_inicial(ji2), .jugador_actual(ja2), .listo(l2), .ocupado(o2));

    inicializador_turnos_param #(.NUM_JUGADORES(3), .RAND_W(4)) dut3 (
        .clk(clk), .reset(reset), .start_inicial(s3), .valor_aleatorio(v3), .fin_turno(f3),
        .jugador_inicial(ji3), .jugador_actual(ja3), .listo(l3), .ocupado(o3));

    inicializador_turnos_param #(.NUM_JUGADORES(4), .RAND_W(4)) dut4 (
        .clk(clk), .reset(reset), .start_inicial(s4), .valor_aleatorio(v4), .fin_turno(f4),
        .jugador_inicial(ji4), .jugador_actual(ja4), .listo(l4), .ocupado(o4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         sel;
        logic [3:0] v;
        int         lat;
        int         jug;
    } vec_t;

    vec_t tbl[8];

    task automatic pulse_start(input bit sel, input logic [3:0] v, input bit fin);
        if (sel) begin s3 = 1'b1; v3 = v; f3 = fin; end
        else     begin s2 = 1'b1; v2 = v; f2 = fin; end
        @(negedge clk);
        s2 = 1'b0; s3 = 1'b0; f2 = 1'b0; f3 = 1'b0;
    endtask

    task automatic pulse_fin(input bit sel);
        if (sel) f3 = 1'b1; else f2 = 1'b1;
        @(negedge clk);
        f2 = 1'b0; f3 = 1'b0;
    endtask

    // Counts cycles from the negedge just after the accepting edge until listo.
    task automatic wait_listo(input bit sel, input string name, output int cyc);
        cyc = 0;
        while (!(sel ? l3 : l2) && cyc < 40) begin
            chk({name, "_ocupado"}, sel ? o3 : o2, 1);
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic lfsr_run(output int cyc, output logic [1:0] jug);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        cyc = 0;
        while (!l4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        jug = ji4;
    endtask

    int         cyc, tot, cyc_a, cyc_b;
    logic [1:0] jug_a, jug_b;

    initial begin
        s2 = 0; f2 = 0; v2 = 0;
        s3 = 0; f3 = 0; v3 = 0;
        s4 = 0; f4 = 0; v4 = 4'd9;
        reset = 1'b1;

        tbl[0] = '{0, 4'd11, 6, 1};
        tbl[1] = '{0, 4'd6,  4, 0};
        tbl[2] = '{0, 4'd0,  1, 0};
        tbl[3] = '{0, 4'd15, 8, 1};
        tbl[4] = '{1, 4'd7,  3, 1};
        tbl[5] = '{1, 4'd2,  1, 2};
        tbl[6] = '{1, 4'd15, 6, 0};
        tbl[7] = '{1, 4'd14, 5, 2};

        lfsr_run(cyc_a, jug_a);
        lfsr_run(cyc_b, jug_b);
        chk("lfsr_lat_bound", (cyc_a >= 1 && cyc_a <= 5) ? 1 : 0, 1);
        chk("lfsr_jug_bound", (jug_a < 4) ? 1 : 0, 1);
        chk("lfsr_repeat_lat", cyc_b, cyc_a);
        chk("lfsr_repeat_jug", jug_b, jug_a);
`ifndef LFSR_INTERNO_EN
        chk("n4_v9_lat", cyc_a, 3);
        chk("n4_v9_jug", jug_a, 1);
`endif

        reset = 1'b1;
        @(negedge clk);
        chk("rst_listo2", l2, 0);
        chk("rst_ocupado2", o2, 0);
        chk("rst_ji2", ji2, 0);
        chk("rst_ja2", ja2, 0);
        chk("rst_listo3", l3, 0);
        chk("rst_ji3", ji3, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_listo", l2, 0);
        chk("idle_ocupado", o2, 0);
        pulse_fin(0);
        chk("idle_fin_ignored", {l2, o2, ja2}, 0);

        for (int i = 0; i < 8; i++) begin
            pulse_start(tbl[i].sel, tbl[i].v, 0);
            chk($sformatf("v%0d_listo_falls", i), tbl[i].sel ? l3 : l2, 0);
            wait_listo(tbl[i].sel, $sformatf("v%0d", i), cyc);
            chk($sformatf("v%0d_lat", i), cyc, tbl[i].lat);
            chk($sformatf("v%0d_ji", i), tbl[i].sel ? ji3 : ji2, tbl[i].jug);
            chk($sformatf("v%0d_ja", i), tbl[i].sel ? ja3 : ja2, tbl[i].jug);
            chk($sformatf("v%0d_ocupado_low", i), tbl[i].sel ? o3 : o2, 0);
        end

        // N=3, v=7 -> first player 1, then rotate 2,0,1
        pulse_start(1, 4'd7, 0);
        wait_listo(1, "rot", cyc);
        chk("rot_ji", ji3, 1);
        pulse_fin(1);
        chk("rot1", ja3, 2);
        pulse_fin(1);
        chk("rot2", ja3, 0);
        pulse_fin(1);
        chk("rot3", ja3, 1);
        chk("rot_ji_held", ji3, 1);

        // start wins over fin_turno in JUGANDO
        pulse_start(1, 4'd2, 1);
        chk("both_listo", l3, 0);
        chk("both_ocupado", o3, 1);
        chk("both_no_rot", ja3, 1);
        chk("both_ji_held", ji3, 1);
        wait_listo(1, "both", cyc);
        chk("both_ji", ji3, 2);
        chk("both_ja", ja3, 2);

        // fin_turno and start_inicial during REDUCIR are ignored
        pulse_start(0, 4'd11, 0);
        repeat (2) @(negedge clk);
        s2 = 1'b1; v2 = 4'd0; f2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0; f2 = 1'b0;
        wait_listo(0, "ign", cyc);
        tot = cyc + 3;
        chk("ign_lat", tot, 6);
        chk("ign_ji", ji2, 1);
        chk("ign_ja", ja2, 1);

        // asynchronous reset mid-REDUCIR
        pulse_start(0, 4'd15, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_ocupado", o2, 0);
        chk("arst_listo", l2, 0);
        chk("arst_ji", ji2, 0);
        chk("arst_ja", ja2, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_idle", {l2, o2, ji2}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
